conv_out_writeback: RTL and testbench

//  Output stage directly downstream of the PE array. Collects one CHANNELS-wide vector of

---
 rtl/conv_out_writeback.sv | 168 ++++++++++++++++
 tb/tb_conv_out_writeback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_writeback.sv
// Output writeback stage: buffers PE-array psum vectors, scales/ReLUs/saturates each channel
// and streams the words into the output SRAM in planar (channel-major) order.
`timescale 1ns/1ps
module conv_out_writeback #(
  parameter int CHANNELS   = 6,
  parameter int PSUM_W     = 32,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         layer_start,
  input  logic [7:0]                   out_size,
  input  logic                         relu_en,
  input  logic                         psum_valid,
  input  logic [CHANNELS*PSUM_W-1:0]   psum_data,
  output logic                         psum_ready,
  output logic                         enable_out_sram,
  output logic [ADDR_W-1:0]            address_out,
  output logic [DATA_W-1:0]            data_out,
  output logic                         layer_done,
  output logic                         busy
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic signed [PSUM_W-1:0] SAT_MAX =
    {{(PSUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] scale_sat(
    input logic signed [PSUM_W-1:0] p,
    input logic                     relu
  );
    logic signed [PSUM_W-1:0] t;
    t = p >>> FRAC_SHIFT;
    if (relu && t[PSUM_W-1]) t = '0;
    if (t > SAT_MAX)      t = SAT_MAX;
    else if (t < SAT_MIN) t = SAT_MIN;
    return t[DATA_W-1:0];
  endfunction

  state_t state, state_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [15:0]       pix, pix_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [15:0]       plane;
  logic              relu_q;

  logic [CHANNELS*PSUM_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             push, pop, emit, done_n, last_pix;

  logic [CHANNELS*PSUM_W-1:0] head;
  logic signed [PSUM_W-1:0]   head_psum;

  assign push      = psum_valid && psum_ready;
  assign head      = mem[rd_ptr];
  assign head_psum = $signed(head[int'(ch)*PSUM_W +: PSUM_W]);
  assign count_n   = count + CNT_W'(push) - CNT_W'(pop);
  // plane==0 makes every pixel the last one of its layer
  assign last_pix  = ({1'b0, pix} + 17'd1) >= {1'b0, plane};
  assign busy      = (count != '0) || (state != IDLE);

  // Next-state / emit decode
  always_comb begin
    state_n = state;
    ch_n    = ch;
    pix_n   = pix;
    base_n  = base;
    emit    = 1'b0;
    pop     = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          emit    = 1'b1;
          ch_n    = CH_W'(1);
          base_n  = base + ADDR_W'(plane);
          state_n = WRITE;
        end
      end
      WRITE: begin
        emit = 1'b1;
        if (ch == LAST_CH) begin
          pop    = 1'b1;
          ch_n   = '0;
          base_n = '0;
          pix_n  = pix + 16'd1;
          if (last_pix)                 state_n = DONE;
          else if (count > CNT_W'(1))   state_n = WRITE;
          else                          state_n = IDLE;
        end else begin
          ch_n   = ch + CH_W'(1);
          base_n = base + ADDR_W'(plane);
        end
      end
      DONE: begin
        done_n  = 1'b1;
        pix_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage boundary: FIFO storage
  always_ff @(posedge clk) begin
    if (push && reset && !layer_start) mem[wr_ptr] <= psum_data;
  end

  // Stage boundary: control state and registered SRAM write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      ch              <= '0;
      pix             <= '0;
      base            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      plane           <= '0;
      relu_q          <= 1'b0;
      psum_ready      <= 1'b0;
      enable_out_sram <= 1'b0;
      address_out     <= '0;
      data_out        <= '0;
      layer_done      <= 1'b0;
    end else if (layer_start) begin
      state           <= IDLE;
      ch              <= '0;
      pix             <= '0;
      base            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      plane           <= {8'd0, out_size} * {8'd0, out_size};
      relu_q          <= relu_en;
      psum_ready      <= 1'b1;
      enable_out_sram <= 1'b0;
      layer_done      <= 1'b0;
    end else begin
      state           <= state_n;
      ch              <= ch_n;
      pix             <= pix_n;
      base            <= base_n;
      wr_ptr          <= wr_ptr + PTR_W'(push);
      rd_ptr          <= rd_ptr + PTR_W'(pop);
      count           <= count_n;
      psum_ready      <= (count_n != FULL_CNT);
      enable_out_sram <= emit;
      layer_done      <= done_n;
      if (emit) begin
        address_out <= base + ADDR_W'(pix);
        data_out    <= scale_sat(head_psum, relu_q);
      end
    end
  end

endmodule

// File: tb/tb_conv_out_writeback.sv
// Scoreboard bench for conv_out_writeback: directed vectors push expected SRAM writes and
// layer_done events; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_conv_out_writeback;

  localparam int CH = 6;
  localparam int PW = 32;
  typedef logic [CH*PW-1:0] vec_t;
  typedef struct {
    bit          done;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk, reset, layer_start, relu_en, psum_valid;
  logic [7:0]  out_size;
  vec_t        psum_data;
  logic        psum_ready, enable_out_sram, layer_done, busy;
  logic [15:0] address_out, data_out;

  conv_out_writeback dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .out_size(out_size),
    .relu_en(relu_en), .psum_valid(psum_valid), .psum_data(psum_data),
    .psum_ready(psum_ready), .enable_out_sram(enable_out_sram),
    .address_out(address_out), .data_out(data_out),
    .layer_done(layer_done), .busy(busy)
  );

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_wr = 0, run_len = 0, max_run = 0;
  bit   saw_ready_low = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int addr, input int data);
    exp_t e;
    e.done = 0; e.addr = 16'(addr); e.data = 16'(data);
    sb.push_back(e);
  endtask

  task automatic exp_done();
    exp_t e;
    e.done = 1; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endtask

  // Monitor: compare every strobe and every layer_done against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (enable_out_sram) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      last_wr = cyc;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", address_out, data_out);
      end else begin
        e = sb.pop_front();
        check("write_is_expected", 32'(e.done), 32'd0);
        check("write_addr", 32'(address_out), 32'(e.addr));
        check("write_data", 32'(data_out), 32'(e.data));
      end
    end else begin
      run_len = 0;
    end
    if (layer_done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_layer_done: got 1, expected 0");
      end else begin
        e = sb.pop_front();
        check("layer_done_expected", 32'(e.done), 32'd1);
        check("layer_done_timing", 32'(cyc), 32'(last_wr + 1));
      end
    end
    if (reset && !psum_ready) saw_ready_low = 1;
  end

  function automatic vec_t ramp(input int b);
    vec_t v;
    for (int c = 0; c < CH; c++) v[c*PW +: PW] = 32'((b + c) << 8);
    return v;
  endfunction

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  // All tasks below start and end on a falling edge
  task automatic send(input vec_t v);
    int n;
    psum_valid = 1'b1;
    psum_data  = v;
    n = 0;
    while (!psum_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL send_ready_timeout: psum_ready 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic start_layer(input logic [7:0] sz, input logic relu);
    layer_start = 1'b1;
    out_size    = sz;
    relu_en     = relu;
    @(negedge clk);
    layer_start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d expected events outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t v3;
    reset = 1'b0; layer_start = 1'b0; out_size = '0; relu_en = 1'b0;
    psum_valid = 1'b0; psum_data = '0;

    // 1. reset behaviour
    repeat (3) @(negedge clk);
    check("rst_enable", 32'(enable_out_sram), 32'd0);
    check("rst_addr", 32'(address_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_done", 32'(layer_done), 32'd0);
    check("rst_ready", 32'(psum_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(psum_ready), 32'd1);

    // 2. out_size=2: 4 pixels, 24 writes, then layer_done
    start_layer(8'd2, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < CH; c++) exp_wr(c*4 + p, c + 1);
      if (p == 3) exp_done();
      send(ramp(1));
    end
    drain();

    // 3. transform: shift, relu, saturation (plane=1, one pixel per layer)
    v3 = mk(-32'sd512, 32'h7FFF_0000, 32'h8000_0000, 32'd0, 32'd255, -32'sd256);
    start_layer(8'd1, 1'b0);
    exp_wr(0, 16'hFFFE); exp_wr(1, 16'h7FFF); exp_wr(2, 16'h8000);
    exp_wr(3, 16'h0000); exp_wr(4, 16'h0000); exp_wr(5, 16'hFFFF);
    exp_done();
    send(v3);
    drain();
    start_layer(8'd1, 1'b1);
    exp_wr(0, 16'h0000); exp_wr(1, 16'h7FFF); exp_wr(2, 16'h0000);
    exp_wr(3, 16'h0000); exp_wr(4, 16'h0000); exp_wr(5, 16'h0000);
    exp_done();
    send(v3);
    drain();

    // 4. back-pressure: 8 back-to-back vectors, plane=9
    start_layer(8'd3, 1'b0);
    saw_ready_low = 0;
    max_run = 0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < CH; c++) exp_wr(c*9 + k, k*8 + c);
      send(ramp(k*8));
    end
    drain();
    check("bp_ready_dropped", 32'(saw_ready_low), 32'd1);
    check("bp_strobe_run", 32'(max_run), 32'd48);

    // 5. layer_start aborts a vector after 3 words
    start_layer(8'd2, 1'b0);
    exp_wr(0, 1); exp_wr(4, 2); exp_wr(8, 3);
    send(ramp(1));
    repeat (3) @(negedge clk);
    start_layer(8'd2, 1'b0);
    check("abort_strobe", 32'(enable_out_sram), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int c = 0; c < CH; c++) exp_wr(c*4, c + 1);
    send(ramp(1));
    drain();

    // 6. reset during the write of pixel 2
    start_layer(8'd2, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < CH; c++) exp_wr(c*4 + p, c + 1);
      send(ramp(1));
    end
    drain();
    exp_wr(2, 10); exp_wr(6, 11);
    send(ramp(10));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_enable", 32'(enable_out_sram), 32'd0);
    check("midrst_addr", 32'(address_out), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_ready", 32'(psum_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_release", 32'(psum_ready), 32'd1);
    // config cleared by reset: plane=0, every vector is its own layer at addr 0
    for (int c = 0; c < CH; c++) exp_wr(0, c + 1);
    exp_done();
    send(ramp(1));
    drain();
    start_layer(8'd2, 1'b0);
    for (int c = 0; c < CH; c++) exp_wr(c*4, c + 1);
    send(ramp(1));
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
